// File: rtl/rfdc_pkg.sv
// Shared types and defaults for the RFDC ADC capture path.
package rfdc_pkg;

  localparam int RFDC_LANES    = 16;
  localparam int RFDC_SAMPLE_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

  // Encoding 2'b11 is reserved and never fires a trigger.
  typedef enum logic [1:0] {
    TRIG_IMM    = 2'b00,
    TRIG_THRESH = 2'b01,
    TRIG_EXT    = 2'b10
  } trig_mode_t;

  function automatic logic cap_busy(input cap_state_t s);
    return (s == ARMED) || (s == CAPTURE);
  endfunction

endpackage

// File: rtl/rfdc_adc_capture_if.sv
// AXI-Stream beat bus carrying packed ADC lanes; master drives data/valid, slave returns ready.
interface rfdc_adc_capture_if #(
  parameter int TDATA_W = 256
);

  logic [TDATA_W-1:0] tdata;
  logic               tvalid;
  logic               tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/rfdc_capture_ram.sv
// Simple dual-port capture buffer: one write port, one registered read port (1-cycle latency).
// Read-during-write to the same address returns the previous contents; no backpressure.
module rfdc_capture_ram #(
  parameter  int WIDTH = 256,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Only the output register is reset so the array still maps onto block RAM.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/rfdc_adc_capture.sv
// Armed/triggered capture of CAPTURE_DEPTH ADC beats into a buffer with running signed peak min/max.
// Write and peak update in the accept cycle, read port 1-cycle latency; tready held high outside reset.
module rfdc_adc_capture
  import rfdc_pkg::*;
#(
  parameter  int DATA_WIDTH    = RFDC_SAMPLE_W,
  parameter  int NUM_LANES     = RFDC_LANES,
  parameter  int CAPTURE_DEPTH = 256,
  parameter  int TRIG_LANE     = 0,
  localparam int TW            = NUM_LANES * DATA_WIDTH,
  localparam int AW            = $clog2(CAPTURE_DEPTH)
) (
  input  logic                         clk,
  input  logic                         resetn,
  rfdc_adc_capture_if.slave            s_axis,
  input  logic                         arm,
  input  logic [1:0]                   trig_mode,
  input  logic signed [DATA_WIDTH-1:0] trig_level,
  input  logic                         ext_trig,
  output logic                         busy,
  output logic                         done,
  output logic [AW:0]                  beat_count,
  output logic signed [DATA_WIDTH-1:0] peak_max,
  output logic signed [DATA_WIDTH-1:0] peak_min,
  input  logic [AW-1:0]                rd_addr,
  output logic [TW-1:0]                rd_data
);

  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(CAPTURE_DEPTH - 1);
  localparam logic signed [DATA_WIDTH-1:0] SMP_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SMP_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  cap_state_t state;
  cap_state_t state_nxt;

  logic                         tready_q;
  logic                         accept;
  logic                         arm_take;
  logic                         trig_hit;
  logic                         wr_en;
  logic [AW-1:0]                wr_addr;
  logic                         last_beat;
  logic signed [DATA_WIDTH-1:0] cur;
  logic signed [DATA_WIDTH-1:0] prev;
  logic                         prev_ok;
  logic signed [DATA_WIDTH-1:0] beat_max;
  logic signed [DATA_WIDTH-1:0] beat_min;

  function automatic logic signed [DATA_WIDTH-1:0] lane_at(input logic [TW-1:0] d, input int k);
    return $signed(d[k*DATA_WIDTH +: DATA_WIDTH]);
  endfunction

  assign s_axis.tready = tready_q;
  assign accept        = s_axis.tvalid && tready_q;
  assign arm_take      = arm && ((state == IDLE) || (state == DONE));
  assign cur           = lane_at(s_axis.tdata, TRIG_LANE);
  assign last_beat     = (beat_count == LAST_BEAT);

  always_comb begin
    trig_hit = 1'b0;
    case (trig_mode_t'(trig_mode))
      TRIG_IMM:    trig_hit = 1'b1;
      TRIG_THRESH: trig_hit = prev_ok && (prev < trig_level) && (cur >= trig_level);
      TRIG_EXT:    trig_hit = ext_trig;
      default:     trig_hit = 1'b0;
    endcase
  end

  // While ARMED the count is zero, so the trigger beat lands at address 0 either way.
  assign wr_en   = accept && (((state == ARMED) && trig_hit) || (state == CAPTURE));
  assign wr_addr = beat_count[AW-1:0];

  always_comb begin
    beat_max = lane_at(s_axis.tdata, 0);
    beat_min = lane_at(s_axis.tdata, 0);
    for (int k = 1; k < NUM_LANES; k++) begin
      if (lane_at(s_axis.tdata, k) > beat_max) begin
        beat_max = lane_at(s_axis.tdata, k);
      end
      if (lane_at(s_axis.tdata, k) < beat_min) begin
        beat_min = lane_at(s_axis.tdata, k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = cap_busy(state);
    done      = (state == DONE);
    case (state)
      IDLE, DONE: begin
        if (arm) begin
          state_nxt = ARMED;
        end
      end
      ARMED: begin
        if (accept && trig_hit) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (accept && last_beat) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Arm has priority: a beat arriving with arm in IDLE/DONE is neither captured nor remembered.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tready_q   <= 1'b0;
      beat_count <= '0;
      peak_max   <= SMP_MIN;
      peak_min   <= SMP_MAX;
      prev       <= '0;
      prev_ok    <= 1'b0;
    end else begin
      tready_q <= 1'b1;
      if (arm_take) begin
        beat_count <= '0;
        peak_max   <= SMP_MIN;
        peak_min   <= SMP_MAX;
        prev_ok    <= 1'b0;
      end else begin
        if (accept) begin
          prev    <= cur;
          prev_ok <= 1'b1;
        end
        if (wr_en) begin
          beat_count <= beat_count + 1'b1;
          if (beat_max > peak_max) begin
            peak_max <= beat_max;
          end
          if (beat_min < peak_min) begin
            peak_min <= beat_min;
          end
        end
      end
    end
  end

  rfdc_capture_ram #(
    .WIDTH (TW),
    .DEPTH (CAPTURE_DEPTH)
  ) u_ram (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (s_axis.tdata),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_rfdc_adc_capture.sv
// Directed bench for rfdc_adc_capture with an 8-beat capture buffer.
module tb_rfdc_adc_capture;
  import rfdc_pkg::*;

  localparam int DW    = 16;
  localparam int NL    = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int TW    = NL * DW;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic                 arm;
  logic [1:0]           trig_mode;
  logic signed [DW-1:0] trig_level;
  logic                 ext_trig;
  logic                 busy;
  logic                 done;
  logic [AW:0]          beat_count;
  logic signed [DW-1:0] peak_max;
  logic signed [DW-1:0] peak_min;
  logic [AW-1:0]        rd_addr;
  logic [TW-1:0]        rd_data;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rfdc_adc_capture_if #(.TDATA_W(TW)) axis ();

  rfdc_adc_capture #(
    .DATA_WIDTH    (DW),
    .NUM_LANES     (NL),
    .CAPTURE_DEPTH (DEPTH),
    .TRIG_LANE     (0)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .s_axis     (axis),
    .arm        (arm),
    .trig_mode  (trig_mode),
    .trig_level (trig_level),
    .ext_trig   (ext_trig),
    .busy       (busy),
    .done       (done),
    .beat_count (beat_count),
    .peak_max   (peak_max),
    .peak_min   (peak_min),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TW-1:0] mk_ramp(input int n);
    logic [TW-1:0] b = '0;
    for (int k = 0; k < NL; k++) b[k*DW +: DW] = DW'(16 * n + k);
    return b;
  endfunction

  function automatic logic [TW-1:0] mk_flat(input int v);
    logic [TW-1:0] b = '0;
    for (int k = 0; k < NL; k++) b[k*DW +: DW] = DW'(v);
    return b;
  endfunction

  task automatic beat(input logic [TW-1:0] d);
    axis.tdata  = d;
    axis.tvalid = 1'b1;
    step();
    axis.tvalid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  initial begin
    logic [TW-1:0] ext_beat;

    resetn      = 1'b0;
    arm         = 1'b0;
    trig_mode   = 2'b00;
    trig_level  = '0;
    ext_trig    = 1'b0;
    rd_addr     = '0;
    axis.tdata  = '0;
    axis.tvalid = 1'b0;
    step(); step(); step();

    // Reset state
    chk("rst_tready", axis.tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", beat_count, 0);
    chk("rst_rd_data", rd_data, 0);
    chk16("rst_peak_max", peak_max, 16'h8000);
    chk16("rst_peak_min", peak_min, 16'h7fff);
    resetn = 1'b1;
    step();
    chk("tready_after_rst", axis.tready, 1);

    // Immediate mode ramp capture
    trig_mode = 2'b00;
    do_arm();
    chk("imm_armed_busy", busy, 1);
    chk("imm_armed_count", beat_count, 0);
    for (int n = 0; n < 8; n++) begin
      beat(mk_ramp(n));
      if (n == 0) chk("imm_count_first", beat_count, 1);
    end
    chk("imm_done", done, 1);
    chk("imm_busy_clear", busy, 0);
    chk("imm_count_full", beat_count, 8);
    chk16("imm_peak_min", peak_min, 16'd0);
    chk16("imm_peak_max", peak_max, 16'd127);
    for (int i = 0; i < 8; i++) begin
      rd_addr = AW'(i);
      step();
      chk($sformatf("imm_rd_%0d", i), rd_data, mk_ramp(i));
    end
    beat(mk_ramp(99));
    chk("done_hold_count", beat_count, 8);
    chk16("done_hold_peak", peak_max, 16'd127);
    rd_addr = '0;
    step();
    chk("done_hold_buf", rd_data, mk_ramp(0));

    // Threshold rising on lane 0
    trig_mode  = 2'b01;
    trig_level = 16'sd1000;
    do_arm();
    chk("rearm_done_clear", done, 0);
    chk16("rearm_peak_max", peak_max, 16'h8000);
    chk16("rearm_peak_min", peak_min, 16'h7fff);
    beat(mk_flat(1100));
    chk("thr_first_beat_no_trig", beat_count, 0);
    beat(mk_flat(0));
    beat(mk_flat(500));
    beat(mk_flat(900));
    chk("thr_below_no_trig", beat_count, 0);
    beat(mk_flat(1100));
    chk("thr_trig_count", beat_count, 1);
    for (int v = 1200; v <= 1800; v += 100) beat(mk_flat(v));
    chk("thr_done", done, 1);
    chk16("thr_peak_min", peak_min, 16'd1100);
    chk16("thr_peak_max", peak_max, 16'd1800);
    rd_addr = 3'd0;
    step();
    chk("thr_rd_0", rd_data, mk_flat(1100));
    rd_addr = 3'd7;
    step();
    chk("thr_rd_7", rd_data, mk_flat(1800));

    // External trigger with valid gaps; ext_trig during a gap must not fire
    trig_mode = 2'b10;
    do_arm();
    for (int n = 0; n < 13; n++) begin
      ext_trig = (n == 5);
      ext_beat = mk_ramp(n);
      beat(ext_beat);
      ext_trig = (n == 2);
      if (n == 5) chk("ext_trig_count", beat_count, 1);
      step(); step(); step();
      ext_trig = 1'b0;
      if (n == 4) chk("ext_gap_no_trig", beat_count, 0);
      if (n == 6) chk("ext_gap_hold", beat_count, 2);
    end
    chk("ext_done", done, 1);
    chk16("ext_peak_min", peak_min, 16'd80);
    chk16("ext_peak_max", peak_max, 16'd207);
    rd_addr = 3'd0;
    step();
    chk("ext_rd_0", rd_data, mk_ramp(5));
    rd_addr = 3'd7;
    step();
    chk("ext_rd_7", rd_data, mk_ramp(12));

    // Arm during capture is ignored
    trig_mode = 2'b00;
    do_arm();
    for (int n = 30; n < 33; n++) beat(mk_ramp(n));
    arm = 1'b1;
    beat(mk_ramp(33));
    arm = 1'b0;
    chk("arm_mid_count", beat_count, 4);
    do_arm();
    chk("arm_mid_idle_count", beat_count, 4);
    chk("arm_mid_busy", busy, 1);
    for (int n = 34; n < 38; n++) beat(mk_ramp(n));
    chk("arm_mid_done", done, 1);
    chk("arm_mid_full", beat_count, 8);
    rd_addr = 3'd0;
    step();
    chk("arm_mid_rd_0", rd_data, mk_ramp(30));

    // Re-arm from DONE with a concurrent beat: arm wins
    arm = 1'b1;
    beat(mk_ramp(50));
    arm = 1'b0;
    chk("rearm_beat_done", done, 0);
    chk("rearm_beat_busy", busy, 1);
    chk("rearm_beat_count", beat_count, 0);
    chk16("rearm_beat_pmax", peak_max, 16'h8000);
    chk16("rearm_beat_pmin", peak_min, 16'h7fff);

    // Reset during capture
    for (int n = 40; n < 44; n++) beat(mk_ramp(n));
    chk("rst_mid_pre_count", beat_count, 4);
    resetn = 1'b0;
    step();
    chk("rst_mid_tready", axis.tready, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_count", beat_count, 0);
    chk16("rst_mid_pmax", peak_max, 16'h8000);
    chk("rst_mid_rd_data", rd_data, 0);
    resetn = 1'b1;
    step();
    chk("rst_mid_tready_back", axis.tready, 1);
    chk("rst_mid_busy_idle", busy, 0);
    step();
    chk("rst_mid_buf_kept", rd_data, mk_ramp(40));

    // Signed extremes in lanes 3 and 12
    do_arm();
    ext_beat = '0;
    ext_beat[3*DW +: DW]  = 16'h8000;
    ext_beat[12*DW +: DW] = 16'h7fff;
    beat(ext_beat);
    for (int n = 1; n < 8; n++) beat(mk_flat((n % 2) ? 5 : -7));
    chk("ext_vals_done", done, 1);
    chk16("signed_peak_min", peak_min, 16'h8000);
    chk16("signed_peak_max", peak_max, 16'h7fff);

    // Reserved trigger mode never fires
    trig_mode = 2'b11;
    do_arm();
    ext_trig = 1'b1;
    for (int n = 0; n < 3; n++) beat(mk_flat(1));
    ext_trig = 1'b0;
    chk("rsv_count", beat_count, 0);
    chk("rsv_busy", busy, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
